muldiv_alu_ctrl: RTL
====================

# muldiv_alu_ctrl

Parametrised successor to the single-cycle ALU control decoder for the MIPS core. It keeps the existing aluop/funct → aluctrl decode and adds an iterative multiply/divide sequencer. The sequencer owns the HI/LO registers and raises a pipeline stall only when a dependent instruction arrives while it is busy. It sits in the execute stage beside the main ALU; the datapath selects HI/LO through the new aluctrl codes.

## Interface
- WIDTH, 32: operand, HI and LO width; must be ≥ 4 and even.
- CTRL_W, 4: aluctrl width.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- valid  in  1  execute-stage instruction is valid.
- aluop  in  2  main-decoder ALU op class.
- funcode  in  6  instruction funct field.
- opa, opb  in  WIDTH  rs / rt operand values.
- aluctrl  out  CTRL_W  combinational ALU control to the main ALU.
- stall  out  1  combinational; freezes fetch, decode and execute.
- busy  out  1  registered; sequencer is not IDLE.
- done  out  1  registered one-cycle pulse when HI/LO take a new result.
- hi, lo  out  WIDTH  registered HI/LO.
- illegal  out  1  combinational; valid && aluctrl == 15.

## Operation
- Decode for aluop 2:
  - funct 32 → 2, 34 → 6, 36 → 0, 37 → 1, 39 → 12, 42 → 7.
  - funct 16 (mfhi) → 8; funct 18 (mflo) → 9.
  - funct 24/25/26/27 (mult/multu/div/divu) → 14, meaning the main ALU does nothing.
  - any other funct → 15.
- Decode for other aluop values: 0 → 2, 1 → 6, 3 → 4.
- Issue: valid && aluctrl == 14 && state IDLE.
  - Operand magnitudes, the sign flags and the op are captured.
  - State moves to MUL or DIV.
- FSM states are IDLE, MUL, DIV and FIX.
  - MUL and DIV each last exactly WIDTH cycles, then go to FIX.
  - FIX lasts one cycle, then returns to IDLE.
- MUL is radix-2 shift-add on the magnitudes and builds a 2×WIDTH product.
- DIV is a restoring divide on the magnitudes, one quotient bit per cycle.
- Signed results (mult, div), applied in FIX:
  - Product is negated when sign(opa) ^ sign(opb).
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of opa.
- Unsigned results are not sign-adjusted.
- Results are written in FIX. Product high half goes to hi and low half to lo. Remainder goes to hi and quotient to lo.
- Divide by zero (opb == 0, either signedness):
  - lo = all ones, hi = opa.
  - Full latency still applies.
  - No exception is raised.
- Signed MIN / −1: lo = MIN, hi = 0. This falls out of the magnitude arithmetic and needs no special case.
- stall = busy && valid && aluctrl ∈ {8, 9, 14}. Independent instructions proceed while busy.
- Issue is suppressed while stall is high, so nothing is captured.
- An instruction with valid low is ignored.

## Timing
- T0 is the issue cycle.
- busy is high from T1 through T(WIDTH+1).
- HI/LO hold the new result, and done pulses, at T(WIDTH+2). At that same edge busy falls.
- Total latency is WIDTH+2 cycles.
- A mfhi/mflo held in execute under stall reads the new value at T(WIDTH+2), and stall is low in that cycle.
- A back-to-back issue can capture at T(WIDTH+2) at the earliest.
- aluctrl, stall and illegal have zero latency and no registers.
- Reset values: state IDLE, hi 0, lo 0, busy 0, done 0.
- Reset mid-operation aborts immediately and asynchronously. The partial result is discarded and HI/LO read 0.

## Configuration
- MULDIV_DIV_EN defined: div and divu decode to 14 and run as specified.
- MULDIV_DIV_EN undefined:
  - funct 26/27 decode to 15, so illegal is raised and no issue occurs.
  - The DIV state and the divider datapath are not compiled.
  - mult, multu, mfhi and mflo are unaffected.

## Structure
- Package alu_pkg holds:
  - the aluctrl code constants 0, 1, 2, 4, 6, 7, 8, 9, 12, 14, 15;
  - the funct constants;
  - the FSM state enum.
- Sub-module muldiv_core holds the FSM, the iterative datapath and HI/LO.
- The top level holds the decode and the stall/illegal logic.

## Test plan
All scenarios use WIDTH = 32.
- Decode sweep, combinational and same cycle:
  - aluop 2 with funct 42 → aluctrl 7; funct 39 → 12; funct 5 → 15 and illegal = 1.
  - aluop 3 → 4.
- mult opa = 0xFFFFFFFD, opb = 5 issued at T0 → at T34: hi = 0xFFFFFFFF, lo = 0xFFFFFFF1, done = 1 for one cycle.
- multu 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- div −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- divu 7 / 0 → lo = 0xFFFFFFFF, hi = 7.
- mflo presented at T5 after a mult issued at T0:
  - stall is high T5–T33 and low at T34;
  - an add at T3 (before the mflo) sees no stall.
- rst_n pulsed low at T10 of a div → busy, hi and lo are 0 immediately; the next issue runs normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, funct values, sequencer states and the aluop/funct decode.
// MULDIV_DIV_EN enables div/divu decode and the DIV sequencer state.
package alu_pkg;

  localparam logic [3:0] C_AND    = 4'd0;
  localparam logic [3:0] C_OR     = 4'd1;
  localparam logic [3:0] C_ADD    = 4'd2;
  localparam logic [3:0] C_OP3    = 4'd4;
  localparam logic [3:0] C_SUB    = 4'd6;
  localparam logic [3:0] C_SLT    = 4'd7;
  localparam logic [3:0] C_MFHI   = 4'd8;
  localparam logic [3:0] C_MFLO   = 4'd9;
  localparam logic [3:0] C_NOR    = 4'd12;
  localparam logic [3:0] C_MULDIV = 4'd14;
  localparam logic [3:0] C_ILL    = 4'd15;

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_FIX} state_e;
`endif

  function automatic logic [3:0] alu_decode(input logic [1:0] aluop, input logic [5:0] f);
    case (aluop)
      2'd0: return C_ADD;
      2'd1: return C_SUB;
      2'd3: return C_OP3;
      default:
        case (f)
          F_ADD:           return C_ADD;
          F_SUB:           return C_SUB;
          F_AND:           return C_AND;
          F_OR:            return C_OR;
          F_NOR:           return C_NOR;
          F_SLT:           return C_SLT;
          F_MFHI:          return C_MFHI;
          F_MFLO:          return C_MFLO;
          F_MULT, F_MULTU: return C_MULDIV;
`ifdef MULDIV_DIV_EN
          F_DIV, F_DIVU:   return C_MULDIV;
`endif
          default:         return C_ILL;
        endcase
    endcase
  endfunction

endpackage

// File: rtl/muldiv_alu_ctrl_if.sv
// Execute-stage bundle between the pipeline and the ALU control / mul-div block.
interface muldiv_alu_ctrl_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    logic              valid;
    logic [1:0]        aluop;
    logic [5:0]        funcode;
    logic [WIDTH-1:0]  opa, opb;
    logic [CTRL_W-1:0] aluctrl;
    logic              stall, busy, done, illegal;
    logic [WIDTH-1:0]  hi, lo;

    modport master (output valid, aluop, funcode, opa, opb,
                    input  aluctrl, stall, busy, done, illegal, hi, lo);
    modport slave  (input  valid, aluop, funcode, opa, opb,
                    output aluctrl, stall, busy, done, illegal, hi, lo);
endinterface

// File: rtl/muldiv_core.sv
// Iterative multiply/divide sequencer owning HI/LO: WIDTH compute cycles plus one sign-fix cycle.
// MULDIV_DIV_EN compiles in the restoring divider and DIV state.
module muldiv_core
  import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic             uns,
`ifdef MULDIV_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ah, al, mb;
    logic             neg_q;
    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   msum;
    logic [2*WIDTH-1:0] prod, prod_n;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign sa    = !uns && opa[WIDTH-1];
    assign sb    = !uns && opb[WIDTH-1];
    assign mag_a = sa ? -opa : opa;
    assign mag_b = sb ? -opb : opb;

    // ah:al is the running product; each step adds the multiplicand then shifts right
    assign msum   = {1'b0, ah} + (al[0] ? {1'b0, mb} : '0);
    assign prod   = {ah, al};
    assign prod_n = neg_q ? -prod : prod;

`ifdef MULDIV_DIV_EN
    logic             div_q, neg_a, dz, dge;
    logic [WIDTH:0]   dsh, dsub;

    // ah is the partial remainder, al shifts dividend bits out and quotient bits in
    assign dsh  = {ah, al[WIDTH-1]};
    assign dsub = dsh - {1'b0, mb};
    assign dge  = dsh >= {1'b0, mb};

    always_comb begin
        res_hi = prod_n[2*WIDTH-1:WIDTH];
        res_lo = prod_n[WIDTH-1:0];
        if (div_q) begin
            // zero divisor leaves |opa| in ah, so the remainder fix restores opa
            res_hi = neg_a ? -ah : ah;
            res_lo = dz ? '1 : (neg_q ? -al : al);
        end
    end
`else
    assign res_hi = prod_n[2*WIDTH-1:WIDTH];
    assign res_lo = prod_n[WIDTH-1:0];
`endif

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ah    <= '0;
            al    <= '0;
            mb    <= '0;
            neg_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q <= 1'b0;
            neg_a <= 1'b0;
            dz    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (issue) begin
                    ah    <= '0;
                    al    <= mag_a;
                    mb    <= mag_b;
                    neg_q <= sa ^ sb;
                    cnt   <= '0;
`ifdef MULDIV_DIV_EN
                    div_q <= is_div;
                    neg_a <= sa;
                    dz    <= (opb == '0);
                    state <= is_div ? ST_DIV : ST_MUL;
`else
                    state <= ST_MUL;
`endif
                end
                ST_MUL: begin
                    {ah, al} <= {msum, al[WIDTH-1:1]};
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) state <= ST_FIX;
                end
`ifdef MULDIV_DIV_EN
                ST_DIV: begin
                    ah    <= dge ? dsub[WIDTH-1:0] : dsh[WIDTH-1:0];
                    al    <= {al[WIDTH-2:0], dge};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) state <= ST_FIX;
                end
`endif
                ST_FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/muldiv_alu_ctrl.sv
// ALU control decode plus HI/LO hazard stall in front of the mul/div sequencer.
// MULDIV_DIV_EN adds div/divu support.
module muldiv_alu_ctrl
  import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    muldiv_alu_ctrl_if.slave  bus
);
    logic [3:0] ctrl;
    logic       hilo_dep;
    logic       issue;

    assign ctrl        = alu_decode(bus.aluop, bus.funcode);
    assign bus.aluctrl = CTRL_W'(ctrl);
    assign hilo_dep    = ctrl inside {C_MFHI, C_MFLO, C_MULDIV};
    assign bus.stall   = bus.busy && bus.valid && hilo_dep;
    assign bus.illegal = bus.valid && (ctrl == C_ILL);
    // busy covers both "not IDLE" and any stall condition
    assign issue       = bus.valid && (ctrl == C_MULDIV) && !bus.busy;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .issue  (issue),
        .uns    (bus.funcode[0]),
`ifdef MULDIV_DIV_EN
        .is_div (bus.funcode[1]),
`endif
        .opa    (bus.opa),
        .opb    (bus.opb),
        .busy   (bus.busy),
        .done   (bus.done),
        .hi     (bus.hi),
        .lo     (bus.lo)
    );
endmodule
